// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo definitions: default widths, reservation-station label type,
// the "no tag" label and functional-unit indices.
package tomasulo_pkg;

  localparam int NREQ_DEF = 4;
  localparam int DW_DEF   = 32;
  localparam int LW_DEF   = 4;

  typedef logic [LW_DEF-1:0] label_t;

  localparam label_t NO_TAG = {LW_DEF{1'b0}};

  localparam logic [1:0] UNIT_ADD  = 2'd0;
  localparam logic [1:0] UNIT_MUL  = 2'd1;
  localparam logic [1:0] UNIT_DIV  = 2'd2;
  localparam logic [1:0] UNIT_LOAD = 2'd3;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational one-hot picker: first requester found scanning upward from
// start, wrapping modulo NREQ.
module rr_pick
  import tomasulo_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IW   = idx_width(NREQ_DEF)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   start,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            found
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0]   sum_s;
  logic [IW-1:0] j_s;
  logic          hit_s;

  // Scan from start; the first hit claims the grant and later slots are masked.
  always_comb begin
    grant = {NREQ{1'b0}};
    idx   = {IW{1'b0}};
    found = 1'b0;
    sum_s = {(IW+1){1'b0}};
    j_s   = {IW{1'b0}};
    hit_s = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      sum_s    = {1'b0, start} + (IW+1)'(k);
      j_s      = (sum_s >= NREQ_W) ? IW'(sum_s - NREQ_W) : sum_s[IW-1:0];
      hit_s    = req[j_s] & ~found;
      grant[j_s] = hit_s;
      idx      = hit_s ? j_s : idx;
      found    = found | hit_s;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one result broadcast per cycle, registered one cycle
// after the grant. Define CDB_RR_EN for round-robin; otherwise lowest index wins.
module cdb_arbiter
  import tomasulo_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int DW   = DW_DEF,
  parameter int LW   = LW_DEF
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*DW-1:0] reqData,
  input  logic [NREQ*LW-1:0] reqLabel,
  input  logic             flush,
  output logic [NREQ-1:0]  ack,
  output logic             cdbValid,
  output logic [DW-1:0]    cdbData,
  output logic [LW-1:0]    cdbLabel,
  output logic             tagErr
);

  localparam int IW = idx_width(NREQ);

  logic [IW-1:0]   start_s;
  logic [IW-1:0]   gidx_s;
  logic [NREQ-1:0] grant_s;
  logic            found_s;
  logic            go_s;
  logic [DW-1:0]   data_s;
  logic [LW-1:0]   label_s;

`ifdef CDB_RR_EN
  logic [IW-1:0] ptr_r;
  assign start_s = ptr_r;
`else
  assign start_s = {IW{1'b0}};
`endif

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req   (req),
    .start (start_s),
    .grant (grant_s),
    .idx   (gidx_s),
    .found (found_s)
  );

  // Reset and flush squash the grant in the same cycle.
  always_comb begin
    ack  = {NREQ{1'b0}};
    go_s = 1'b0;
    if (RST || flush) begin
      ack  = {NREQ{1'b0}};
      go_s = 1'b0;
    end else begin
      ack  = grant_s;
      go_s = found_s;
    end
  end

  // Route the winner's result and tag toward the broadcast register.
  always_comb begin
    data_s  = {DW{1'b0}};
    label_s = {LW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      data_s  = data_s  | ({DW{gidx_s == IW'(i)}} & reqData[i*DW +: DW]);
      label_s = label_s | ({LW{gidx_s == IW'(i)}} & reqLabel[i*LW +: LW]);
    end
  end

  // Broadcast register; data and tag hold when nothing is granted.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      cdbValid <= 1'b0;
      cdbData  <= {DW{1'b0}};
      cdbLabel <= {LW{1'b0}};
      tagErr   <= 1'b0;
    end else begin
      cdbValid <= go_s;
      if (go_s) begin
        cdbData  <= data_s;
        cdbLabel <= label_s;
      end
      if (go_s && (label_s == LW'(NO_TAG))) begin
        tagErr <= 1'b1;
      end
    end
  end

`ifdef CDB_RR_EN
  // Next search starts just past the last winner.
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      ptr_r <= {IW{1'b0}};
    end else if (go_s) begin
      ptr_r <= (gidx_s == IW'(NREQ-1)) ? {IW{1'b0}} : gidx_s + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with a per-cycle reference model; follows
// the CDB_RR_EN setting of the build.
module tb_cdb_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;
  localparam int LW   = 4;
`ifdef CDB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              RST;
  logic [NREQ-1:0]   req;
  logic [NREQ*DW-1:0] reqData;
  logic [NREQ*LW-1:0] reqLabel;
  logic              flush;
  logic [NREQ-1:0]   ack;
  logic              cdbValid;
  logic [DW-1:0]     cdbData;
  logic [LW-1:0]     cdbLabel;
  logic              tagErr;

  int n_cmp = 0;
  int n_bad = 0;

  cdb_arbiter #(.NREQ(NREQ), .DW(DW), .LW(LW)) dut (
    .clk      (clk),
    .RST      (RST),
    .req      (req),
    .reqData  (reqData),
    .reqLabel (reqLabel),
    .flush    (flush),
    .ack      (ack),
    .cdbValid (cdbValid),
    .cdbData  (cdbData),
    .cdbLabel (cdbLabel),
    .tagErr   (tagErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: scan from p modulo NREQ, first requester wins.
  function automatic logic [3:0] model_ack(input logic [3:0] r, input logic f,
                                           input logic rs, input int p);
    if (rs !== 1'b0 || f) return 4'b0000;
    for (int k = 0; k < NREQ; k++) begin
      int j = (p + k) % NREQ;
      if (r[j]) return 4'(1 << j);
    end
    return 4'b0000;
  endfunction

  function automatic int idx_of(input logic [3:0] oh);
    for (int i = 0; i < NREQ; i++) if (oh[i]) return i;
    return 0;
  endfunction

  int          m_ptr = 0;
  logic        m_valid = 1'b0;
  logic [31:0] m_data = 32'd0;
  logic [3:0]  m_label = 4'd0;
  logic        m_err = 1'b0;
  logic [3:0]  m_ack;
  int          m_gidx;

  assign m_ack  = model_ack(req, flush, RST, RR ? m_ptr : 0);
  assign m_gidx = idx_of(m_ack);

  always @(posedge clk or posedge RST) begin
    if (RST) begin
      m_valid <= 1'b0;
      m_data  <= 32'd0;
      m_label <= 4'd0;
      m_err   <= 1'b0;
      m_ptr   <= 0;
    end else begin
      m_valid <= (m_ack != 4'b0000);
      if (m_ack != 4'b0000) begin
        m_data  <= reqData[m_gidx*DW +: DW];
        m_label <= reqLabel[m_gidx*LW +: LW];
        if (reqLabel[m_gidx*LW +: LW] == 4'd0) m_err <= 1'b1;
        m_ptr <= (m_gidx + 1) % NREQ;
      end
    end
  end

  always @(negedge clk) begin
    check("ack", 64'(ack), 64'(m_ack));
    check("cdbValid", 64'(cdbValid), 64'(m_valid));
    check("cdbData", 64'(cdbData), 64'(m_data));
    check("cdbLabel", 64'(cdbLabel), 64'(m_label));
    check("tagErr", 64'(tagErr), 64'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input int u, input logic [31:0] d, input logic [3:0] l);
    reqData[u*DW +: DW]  = d;
    reqLabel[u*LW +: LW] = l;
  endtask

  logic [3:0] rr_seq[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [3:0] vr[8]     = '{4'b0011, 4'b0110, 4'b1111, 4'b0000,
                            4'b1010, 4'b0101, 4'b1100, 4'b1001};
  logic       vf[8]     = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    RST = 1'b1;
    req = 4'b1111;
    flush = 1'b0;
    reqData = '0;
    reqLabel = '0;
    put(0, 32'h0000_0010, 4'd1);
    put(1, 32'h0000_0006, 4'd3);
    put(2, 32'h0000_0022, 4'd5);
    put(3, 32'h0000_0033, 4'd7);

    @(negedge clk);
    check("rst_ack", 64'(ack), 64'd0);
    check("rst_valid", 64'(cdbValid), 64'd0);
    check("rst_data", 64'(cdbData), 64'd0);
    check("rst_tagerr", 64'(tagErr), 64'd0);

    // Single grant and its one-cycle broadcast
    tick(); RST = 1'b0; req = 4'b0010;
    @(negedge clk); check("t1_ack", 64'(ack), 64'b0010);
    tick(); req = 4'b0000;
    @(negedge clk);
    check("t1_valid", 64'(cdbValid), 64'd1);
    check("t1_data", 64'(cdbData), 64'h6);
    check("t1_label", 64'(cdbLabel), 64'd3);
    tick();
    @(negedge clk);
    check("t1_valid_drop", 64'(cdbValid), 64'd0);
    check("t1_data_hold", 64'(cdbData), 64'h6);

    // All four requesting from reset
    tick(); RST = 1'b1;
    tick(); RST = 1'b0; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rr_seq", 64'(ack), RR ? 64'(rr_seq[i]) : 64'b0001);
      tick();
    end

    // Wrap from unit 3 back to unit 0
    req = 4'b1000;
    @(negedge clk); check("wrap_pre", 64'(ack), 64'b1000);
    tick(); req = 4'b1001;
    @(negedge clk); check("wrap_u0", 64'(ack), 64'b0001);
    tick();
    @(negedge clk); check("wrap_u3", 64'(ack), RR ? 64'b1000 : 64'b0001);
    tick(); req = 4'b0000;

    // Flush squashes the grant, then unit 2 wins
    flush = 1'b1; req = 4'b0100;
    @(negedge clk); check("flush_ack", 64'(ack), 64'd0);
    tick(); flush = 1'b0;
    @(negedge clk);
    check("flush_valid", 64'(cdbValid), 64'd0);
    check("flush_then_ack", 64'(ack), 64'b0100);
    tick(); req = 4'b0000;
    @(negedge clk); check("flush_data", 64'(cdbData), 64'h22);

    // Label 0 is broadcast and latches tagErr
    put(2, 32'h0000_ABCD, 4'd0);
    tick(); req = 4'b0100;
    @(negedge clk); check("tag0_pre_err", 64'(tagErr), 64'd0);
    tick(); req = 4'b0000; put(2, 32'h0000_0022, 4'd5);
    @(negedge clk);
    check("tag0_valid", 64'(cdbValid), 64'd1);
    check("tag0_data", 64'(cdbData), 64'hABCD);
    check("tag0_err", 64'(tagErr), 64'd1);

    for (int i = 0; i < 8; i++) begin
      tick(); req = vr[i]; flush = vf[i];
      @(negedge clk);
    end
    check("tag0_sticky", 64'(tagErr), 64'd1);
    tick(); req = 4'b0000; flush = 1'b0; RST = 1'b1;
    @(negedge clk); check("tag0_cleared", 64'(tagErr), 64'd0);
    tick(); RST = 1'b0; req = 4'b1111;

    // Asynchronous reset in the middle of a broadcast
    tick(); req = 4'b0000;
    @(negedge clk); check("async_pre", 64'(cdbValid), 64'd1);
    #3 RST = 1'b1;
    #1 check("async_clr", 64'(cdbValid), 64'd0);
    req = 4'b1111;
    tick();
    tick(); RST = 1'b0;
    @(negedge clk); check("async_first", 64'(ack), 64'b0001);
    tick(); req = 4'b0000;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of functional-unit requesters (adder, multiplier, divider, load).
REQ-002 Parameter DW, default 32, result data width.
REQ-003 Parameter LW, default 4, reservation-station label width; label 0 means "no tag".
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 RST  input  1  asynchronous, active-high reset.
REQ-006 req  input  NREQ  per-unit result-ready request, level, held until acked.
REQ-007 reqData  input  NREQ*DW  packed results, unit i at bits [i*DW +: DW].
REQ-008 reqLabel  input  NREQ*LW  packed tags, unit i at bits [i*LW +: LW].
REQ-009 flush  input  1  squash: no grant this cycle, CDB invalid next cycle.
REQ-010 ack  output  NREQ  combinational one-hot grant; unit frees its result slot on the edge where ack is high.
REQ-011 cdbValid  output  1  registered broadcast-valid.
REQ-012 cdbData  output  DW  registered broadcast data.
REQ-013 cdbLabel  output  LW  registered broadcast tag.
REQ-014 tagErr  output  1  sticky protocol-error flag.

Function
REQ-015 ack is at most one-hot; ack[i] is never high unless req[i] is high.
REQ-016 With flush=0 and any req high, exactly one ack is high in that same cycle.
REQ-017 Latency: a grant in cycle N drives cdbValid=1 with that unit's data/label throughout cycle N+1, for exactly one cycle per grant.
REQ-018 No grant in cycle N (no req or flush=1): cdbValid=0 in cycle N+1; cdbData/cdbLabel hold their previous values.
REQ-019 Arbitration state: pointer ptr (log2 NREQ bits); the search starts at index ptr and wraps modulo NREQ.
REQ-020 After a grant to unit g, ptr becomes (g+1) mod NREQ; g=NREQ-1 wraps ptr to 0; ptr is unchanged when nothing is granted.
REQ-021 Back-to-back: a unit holding req high may be granted on consecutive cycles only when no other unit requests.
REQ-022 flush=1 forces ack=0 regardless of req; ptr is unchanged; the flush does not affect tagErr.
REQ-023 A granted request carrying label 0 is still broadcast and sets tagErr=1 from the next cycle until reset.
REQ-024 Requests that drop without an ack are not errors and leave no state.

Reset
REQ-025 While RST=1: cdbValid=0, cdbData=0, cdbLabel=0, tagErr=0, ptr=0, and ack=0 combinationally.
REQ-026 RST asserted mid-broadcast clears cdbValid immediately (asynchronously); the first grant after release searches from index 0.

Configuration
REQ-027 Macro CDB_RR_EN defined: round-robin arbitration per REQ-019..REQ-021.
REQ-028 CDB_RR_EN undefined: fixed priority, lowest index wins; ptr is not implemented; all other requirements are unchanged.

Structure
REQ-029 Shared package tomasulo_pkg holds the NREQ/DW/LW defaults, the label type, the constant NO_TAG=0, and the unit index constants.
REQ-030 One sub-module rr_pick: combinational one-hot picker taking req and a start index and returning grant plus granted index; the top instantiates it once.

Verification
REQ-031 Reset, then req=4'b0010 with data 0x0000_0006 and label 3 -> ack=4'b0010 in cycle N; next cycle cdbValid=1, cdbData=6, cdbLabel=3; the cycle after, cdbValid=0.
REQ-032 RR: req=4'b1111 held for 5 cycles from reset -> ack sequence 0001, 0010, 0100, 1000, 0001.
REQ-033 Wrap: last grant to unit 3, then req=4'b1001 -> unit 0 is granted; the next cycle, unit 3 is granted.
REQ-034 flush=1 with req=4'b0100 -> ack=0; next cycle cdbValid=0; flush=0 the following cycle -> unit 2 is granted.
REQ-035 Granted label 0 -> broadcast occurs and tagErr rises the next cycle; tagErr stays high until RST=1 clears it.
REQ-036 RST pulse while cdbValid=1 -> cdbValid=0 without waiting for a clock edge; the next grant with req=4'b1111 goes to unit 0.
